periph_bus_responder: RTL
=========================

PERIPH_BUS_RESPONDER -- requirements
Module: periph_bus_responder

Interface
REQ-001 Parameter PERIPHERAL_BASE, default 64'h2000_0000, base address of the peripheral window.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to d_ready; legal range 1..15.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_valid  input  1  core requests a peripheral access; held high while the core is stalled.
REQ-006 addr  input  64  byte address of the access; stable while d_valid is high.
REQ-007 mem_read  input  1  access is a load.
REQ-008 mem_write  input  1  access is a store.
REQ-009 wdata  input  64  store data.
REQ-010 d_ready  output  1  one-cycle completion pulse; releases the core stall.
REQ-011 rdata  output  64  load data; meaningful only while d_ready=1.
REQ-012 bus_err  output  1  one-cycle pulse, coincident with d_ready, for an unmapped or misaligned access.
REQ-013 irq  output  1  level, equals STATUS bit 0.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 In IDLE with d_valid=1, the block SHALL accept the request, load wait counter with LATENCY-1, and enter WAIT; if LATENCY=1, it SHALL enter RESP directly.
REQ-016 In WAIT, the counter SHALL decrement each cycle and enter RESP when it reaches 0; d_ready=1 occurs exactly LATENCY cycles after the acceptance cycle.
REQ-017 In RESP, d_ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE; any write SHALL commit at the end of the RESP cycle.
REQ-018 If d_valid is still high in the IDLE cycle after RESP, the block SHALL treat it as a new request (back-to-back accesses); no idle gap beyond one IDLE cycle is required.
REQ-019 If d_valid falls in WAIT or RESP (flush), the block SHALL abort: return to IDLE, suppress d_ready and bus_err, and commit no write.
REQ-020 Offset is addr-PERIPHERAL_BASE (64-bit); decode is valid only when addr>=PERIPHERAL_BASE, offset<0x20 and offset[2:0]=0.
REQ-021 Register map: 0x00 SCRATCH, read/write.
REQ-022 Register map: 0x08 CYCLE, read-only, free-running 64-bit counter, +1 every cycle, wraps from all-ones to 0.
REQ-023 Register map: 0x10 TIMER_CMP, read/write.
REQ-024 Register map: 0x18 STATUS, bit0 sticky match, write-1-to-clear; other bits read 0.
REQ-025 STATUS[0] SHALL set in the cycle after CYCLE==TIMER_CMP; if set and W1C commit coincide, set SHALL win.
REQ-026 A write to CYCLE SHALL be ignored without error.
REQ-027 A read SHALL return the register value sampled in the RESP cycle, before that cycle's commit.
REQ-028 mem_read and mem_write both high SHALL perform the write and return the pre-write value.
REQ-029 d_valid with neither mem_read nor mem_write SHALL complete normally with rdata=0 and no write.
REQ-030 An unmapped or misaligned access SHALL complete with d_ready=1, bus_err=1 and rdata=0, with no write committed.
REQ-031 rdata SHALL be 0 whenever d_ready=0.

Reset
REQ-032 On reset=1 at a clock edge: FSM IDLE, wait counter 0, d_ready=0, bus_err=0, rdata=0.
REQ-033 On reset: SCRATCH=0, CYCLE=0, TIMER_CMP=all-ones, STATUS=0, irq=0.
REQ-034 Reset SHALL override any in-flight request; no write commits and no d_ready is issued for it.

Verification
REQ-035 Write then read: write SCRATCH (addr 0x2000_0000) = 0xDEAD_BEEF, LATENCY=2 -> d_ready exactly 2 cycles after acceptance; subsequent read returns 0xDEAD_BEEF with bus_err=0.
REQ-036 Timer: write TIMER_CMP=20 right after reset -> irq=1 the cycle after CYCLE==20; write STATUS=1 -> irq=0 after commit; write 0 to STATUS -> no change.
REQ-037 Error: read at 0x2000_0020, then at 0x2000_0004 -> each gets d_ready=1, bus_err=1, rdata=0; a write at 0x2000_0021 leaves all registers unchanged.
REQ-038 Abort and back-to-back: drop d_valid in WAIT during a SCRATCH write of 5 -> no d_ready and SCRATCH unchanged; two consecutive held requests -> two d_ready pulses separated by LATENCY+1 cycles.
REQ-039 Reset mid-WAIT during a write of 7 to SCRATCH -> no d_ready, SCRATCH=0, CYCLE restarts at 0.
REQ-040 Latency sweep LATENCY=1 and 15 -> d_ready exactly 1 and 15 cycles after acceptance.

Source files
------------

// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral responder: fixed-latency handshake with a small register
// file (scratch, free-running cycle counter, timer compare, sticky match status).
module periph_bus_responder #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int unsigned LATENCY         = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [63:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] wdata,
    output logic        d_ready,
    output logic [63:0] rdata,
    output logic        bus_err,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_scratch, r_cycle, r_cmp;
    logic        r_status;

    logic [63:0] w_off, w_regval;
    logic        w_hit, w_rsp, w_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (d_valid) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // A dropped d_valid is a flush from the core: abandon the access.
                if (!d_valid) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_off = addr - PERIPHERAL_BASE;
    assign w_hit = (addr >= PERIPHERAL_BASE) && (w_off < 64'h20) && (w_off[2:0] == 3'b000);
    assign w_rsp = (r_state == RESP) && d_valid;
    assign w_we  = w_rsp && w_hit && mem_write;

    always_comb begin
        w_regval = '0;
        case (w_off[4:3])
            2'd0: w_regval = r_scratch;
            2'd1: w_regval = r_cycle;
            2'd2: w_regval = r_cmp;
            2'd3: w_regval = {63'b0, r_status};
            default: w_regval = '0;
        endcase
    end

    assign d_ready = w_rsp;
    assign bus_err = w_rsp && !w_hit;
    assign rdata   = (w_rsp && w_hit && mem_read) ? w_regval : 64'b0;
    assign irq     = r_status;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch <= '0;
            r_cycle   <= '0;
            r_cmp     <= '1;
            r_status  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_we && w_off[4:3] == 2'd0) r_scratch <= wdata;
            if (w_we && w_off[4:3] == 2'd2) r_cmp <= wdata;
            // A match in the same cycle as a W1C commit keeps the flag set.
            if (r_cycle == r_cmp)
                r_status <= 1'b1;
            else if (w_we && w_off[4:3] == 2'd3 && wdata[0])
                r_status <= 1'b0;
        end
    end
endmodule
